// File: rtl/dsp48_ctrl_pkg.sv
// Shared control definitions for the DSP48A1-style MAC sequencer:
// OPMODE codes driven to the slice and the sequencer state encoding.
package dsp48_ctrl_pkg;

    // X=M, Z=0 : P <= product (first term of a sum)
    localparam logic [7:0] OPM_FIRST = 8'h01;
    // X=M, Z=P : P <= P + product
    localparam logic [7:0] OPM_ACC   = 8'h09;
    // X=0, Z=P : P unchanged
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/dsp_opmode_dly.sv
// OPMODE delay line: aligns the opmode chosen at operand acceptance with
// the product arriving at the slice post-adder. DLY=0 is a pass-through.
module dsp_opmode_dly
    import dsp48_ctrl_pkg::*;
#(
    parameter int unsigned DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_i,
    input  logic [7:0] d_i,
    output logic [7:0] q_o
);

    generate
        if (DLY == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_sr
            logic [7:0] sr_q [DLY];

            // Shift on the slice CE so the line advances in step with the A/B/M registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DLY; i++) begin
                        sr_q[i] <= OPM_HOLD;
                    end
                end else if (ce_i) begin
                    sr_q[0] <= d_i;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_seq.sv
// Control sequencer for one DSP48A1-style slice running a LEN-term
// multiply-accumulate job. Operand data goes straight to the slice; this
// block handles the handshake, OPMODE sequencing, P clear and completion.
// Optional macro DSP_MAC_SEQ_PERF_EN adds the bubble_cnt output.
module dsp_mac_seq
    import dsp48_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned OPM_DLY = 2,
    parameter int unsigned P_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dsp_ce,
    output logic             dsp_rstp,
    output logic [7:0]       dsp_opmode,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
`ifdef DSP_MAC_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    // Cycles spent in DRAIN: opmode delay plus the P register
    localparam int unsigned DRN_CYC  = OPM_DLY + P_LAT;
    localparam int unsigned DRN_W    = (DRN_CYC > 1) ? $clog2(DRN_CYC) : 1;
    localparam int unsigned DRN_LAST = (DRN_CYC > 0) ? DRN_CYC - 1 : 0;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic [7:0]       opm_push;

    // Next-state, counters and slice controls, all decoded from the current state
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        opm_push = OPM_HOLD;
        in_ready = 1'b0;
        dsp_ce   = 1'b0;
        dsp_rstp = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = RUN;
                    end else begin
                        state_d = CLR;
                    end
                end
            end
            CLR: begin
                dsp_ce   = 1'b1;
                dsp_rstp = 1'b1;
                state_d  = DONE;
            end
            RUN: begin
                dsp_ce   = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d    = cnt_q + 1'b1;
                    opm_push = (cnt_q == '0) ? OPM_FIRST : OPM_ACC;
                    // cnt_q < len_q here, so the increment never wraps
                    if (cnt_d == len_q) begin
                        drn_d   = '0;
                        state_d = (DRN_CYC == 0) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                dsp_ce = 1'b1;
                if (drn_q == DRN_W'(DRN_LAST)) begin
                    state_d = DONE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign sample_cnt = cnt_q;

    dsp_opmode_dly #(
        .DLY (OPM_DLY)
    ) u_opm_dly (
        .clk  (clk),
        .rst  (rst),
        .ce_i (dsp_ce),
        .d_i  (opm_push),
        .q_o  (dsp_opmode)
    );

`ifdef DSP_MAC_SEQ_PERF_EN
    logic [CNT_W-1:0] bub_q, bub_d;

    // Saturating count of RUN cycles without an operand
    always_comb begin
        bub_d = bub_q;
        if (state_q == IDLE && start) begin
            bub_d = '0;
        end else if (state_q == RUN && !in_valid && bub_q != '1) begin
            bub_d = bub_q + 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bub_q <= '0;
        end else begin
            bub_q <= bub_d;
        end
    end

    assign bubble_cnt = bub_q;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed testbench for dsp_mac_seq with a small behavioural slice model
// (A/B reg, M reg, P reg) driven by the sequencer's controls.
module tb_dsp_mac_seq;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             dsp_ce;
    logic             dsp_rstp;
    logic [7:0]       dsp_opmode;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
`ifdef DSP_MAC_SEQ_PERF_EN
    logic [CNT_W-1:0] bubble_cnt;
`endif

    logic [7:0]  a_in = '0, b_in = '0;
    logic [7:0]  a_q = '0, b_q = '0;
    logic [15:0] m_q = '0;
    logic [31:0] p_q = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dsp_mac_seq #(
        .CNT_W   (CNT_W),
        .OPM_DLY (2),
        .P_LAT   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dsp_ce     (dsp_ce),
        .dsp_rstp   (dsp_rstp),
        .dsp_opmode (dsp_opmode),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt)
`ifdef DSP_MAC_SEQ_PERF_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    // Slice model: A/B -> M -> post-adder/P, all on the common CE
    always @(posedge clk) begin
        if (dsp_ce) begin
            a_q <= a_in;
            b_q <= b_in;
            m_q <= a_q * b_q;
            if (dsp_rstp) begin
                p_q <= '0;
            end else begin
                case (dsp_opmode)
                    8'h01:   p_q <= 32'(m_q);
                    8'h09:   p_q <= p_q + 32'(m_q);
                    8'h08:   p_q <= p_q;
                    default: p_q <= 'x;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of operand inputs, then advance to the next falling edge
    task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",  in_ready,   0);
        chk("rst_ce",     dsp_ce,     0);
        chk("rst_rstp",   dsp_rstp,   0);
        chk("rst_busy",   busy,       0);
        chk("rst_done",   done,       0);
        chk("rst_cnt",    sample_cnt, 0);
        chk("rst_opm",    dsp_opmode, 8'h08);
`ifdef DSP_MAC_SEQ_PERF_EN
        chk("rst_bub",    bubble_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // len=4, valid held high: 1*2+3*4+5*6+7*8 = 100
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy",  busy,       1);
        chk("t1_ready", in_ready,   1);
        chk("t1_cnt0",  sample_cnt, 0);
        cyc(1, 1, 2);
        chk("t1_cnt1",  sample_cnt, 1);
        cyc(1, 3, 4);
        chk("t1_opm0",  dsp_opmode, 8'h01);
        cyc(1, 5, 6);
        chk("t1_opm1",  dsp_opmode, 8'h09);
        cyc(1, 7, 8);
        chk("t1_drn_ready", in_ready,   0);
        chk("t1_drn_ce",    dsp_ce,     1);
        chk("t1_cnt4",      sample_cnt, 4);
        chk("t1_opm2",      dsp_opmode, 8'h09);
        cyc(0, 0, 0);
        chk("t1_opm3",      dsp_opmode, 8'h09);
        cyc(0, 0, 0);
        chk("t1_opm4",      dsp_opmode, 8'h08);
        chk("t1_early",     done,       0);
        cyc(0, 0, 0);
        chk("t1_done",      done,       1);
        chk("t1_done_ce",   dsp_ce,     0);
        chk("t1_p",         p_q,        100);
        cyc(0, 0, 0);
        chk("t1_pulse",     done,       0);
        chk("t1_idle",      busy,       0);
        chk("t1_hold_cnt",  sample_cnt, 4);

        // len=3, valid 1,0,0,1,0,1: 2*3+4*5+6*7 = 68
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("t2_cnt0",  sample_cnt, 0);
        cyc(1, 2, 3);
        chk("t2_cnt1",  sample_cnt, 1);
        cyc(0, 0, 0);
        chk("t2_cnt2",  sample_cnt, 1);
        chk("t2_opm0",  dsp_opmode, 8'h01);
        chk("t2_ready", in_ready,   1);
        cyc(0, 0, 0);
        chk("t2_cnt3",  sample_cnt, 1);
        chk("t2_opm1",  dsp_opmode, 8'h08);
        cyc(1, 4, 5);
        chk("t2_cnt4",  sample_cnt, 2);
        chk("t2_opm2",  dsp_opmode, 8'h08);
        cyc(0, 0, 0);
        chk("t2_cnt5",  sample_cnt, 2);
        chk("t2_opm3",  dsp_opmode, 8'h09);
        cyc(1, 6, 7);
        chk("t2_cnt6",  sample_cnt, 3);
        chk("t2_opm4",  dsp_opmode, 8'h08);
        chk("t2_drn",   in_ready,   0);
        cyc(0, 0, 0);
        chk("t2_opm5",  dsp_opmode, 8'h09);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t2_done",  done,       1);
        chk("t2_p",     p_q,        68);
`ifdef DSP_MAC_SEQ_PERF_EN
        chk("t2_bub",   bubble_cnt, 3);
`endif
        cyc(0, 0, 0);

        // len=3, valid 1,0,1,0,0,1: 1+4+9 = 14
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
`ifdef DSP_MAC_SEQ_PERF_EN
        chk("t3_bub_clr", bubble_cnt, 0);
`endif
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        cyc(1, 2, 2);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t3_ready", in_ready,   1);
        cyc(1, 3, 3);
        chk("t3_cnt",   sample_cnt, 3);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t3_early", done,       0);
        cyc(0, 0, 0);
        chk("t3_done",  done,       1);
        chk("t3_p",     p_q,        14);
`ifdef DSP_MAC_SEQ_PERF_EN
        chk("t3_bub",   bubble_cnt, 3);
`endif
        cyc(0, 0, 0);

        // len=0: one clear cycle then done, P=0
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_rstp",  dsp_rstp, 1);
        chk("t4_ce",    dsp_ce,   1);
        chk("t4_busy",  busy,     1);
        chk("t4_ready", in_ready, 0);
        chk("t4_nodone", done,    0);
        @(negedge clk);
        chk("t4_done",  done,     1);
        chk("t4_rstp0", dsp_rstp, 0);
        chk("t4_p",     p_q,      0);
        @(negedge clk);
        chk("t4_idle",  busy,     0);

        // start held during RUN/DRAIN is ignored: len=2, 9+16 = 25
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        len = 8'd5;
        cyc(1, 3, 3);
        chk("t5_cnt1",  sample_cnt, 1);
        cyc(1, 4, 4);
        chk("t5_drn",   in_ready,   0);
        chk("t5_cnt2",  sample_cnt, 2);
        start = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t5_done",  done,       1);
        chk("t5_p",     p_q,        25);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t5_noq",   busy,       0);

        // reset in the 2nd RUN cycle, then a fresh len=2 job: 10+21 = 31
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        cyc(1, 5, 5);
        rst = 1'b1;
        cyc(1, 6, 6);
        rst = 1'b0;
        chk("t6_ready", in_ready,   0);
        chk("t6_ce",    dsp_ce,     0);
        chk("t6_busy",  busy,       0);
        chk("t6_done",  done,       0);
        chk("t6_cnt",   sample_cnt, 0);
        chk("t6_opm",   dsp_opmode, 8'h08);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t6_nodone", done,      0);
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        cyc(1, 2, 5);
        cyc(1, 3, 7);
        chk("t6_cnt2",  sample_cnt, 2);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t6_jdone", done,       1);
        chk("t6_p",     p_q,        31);
        cyc(0, 0, 0);

        // maximum length for CNT_W=8 completes without wrap
        start = 1'b1; len = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 254; i++) begin
            cyc(1, 1, 1);
        end
        chk("t7_ready254", in_ready,   1);
        chk("t7_cnt254",   sample_cnt, 254);
        cyc(1, 1, 1);
        chk("t7_drn",      in_ready,   0);
        chk("t7_cnt255",   sample_cnt, 255);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t7_done",     done,       1);
        chk("t7_p",        p_q,        255);
        cyc(0, 0, 0);
        chk("t7_idle",     busy,       0);
        chk("t7_hold",     sample_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dsp_mac_seq.md
Name: dsp_mac_seq

Overview:
- Sequencer for one DSP48A1-style slice running a multiply-accumulate job over LEN operand pairs.
- Accepts a job command, then operand pairs on a valid/ready stream.
- Drives the slice's OPMODE, clock-enable and P-reset controls, and pulses done when the final sum is in the P register.
- Sits between the host/job logic and the slice; operand data flows to the A/B ports directly, and only the control is sequenced here.

Parameters:
- CNT_W, 16, width of the job length and sample counters
- OPM_DLY, 2, cycles from operand acceptance to the product reaching the post-adder (A/B reg + M reg); opmode is delayed by this amount
- P_LAT, 1, cycles from post-adder to valid P output (P register)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- len  in  CNT_W  number of operand pairs in the job; captured with start
- in_valid  in  1  operand pair present on the slice A/B inputs
- in_ready  out  1  controller accepts the operand pair this cycle
- dsp_ce  out  1  common CE to A/B/M/P/OPMODE registers
- dsp_rstp  out  1  synchronous clear of the P register
- dsp_opmode  out  8  OPMODE to the slice, already delayed by OPM_DLY
- busy  out  1  job in progress (any state except IDLE)
- done  out  1  one-cycle pulse: P holds the final sum
- sample_cnt  out  CNT_W  pairs accepted so far in the current job

Behaviour:
- Reset state (rst=1 at a clock edge):
  - state=IDLE; in_ready=0, dsp_ce=0, dsp_rstp=0, busy=0, done=0, sample_cnt=0
  - dsp_opmode=8'h08; opmode delay line filled with 8'h08
- Reset mid-job aborts immediately. No done pulse is issued. P is not cleared by this block; the slice's own RSTP covers that.
- Opmode codes:
  - FIRST=8'h01 (X=M, Z=0)
  - ACC=8'h09 (X=M, Z=P)
  - HOLD=8'h08 (X=0, Z=P); P unchanged
- IDLE:
  - start=1 and len!=0: capture len, clear sample_cnt, go RUN.
  - start=1 and len==0: go CLR.
- CLR (len==0 only): one cycle with dsp_rstp=1 and dsp_ce=1, then go DONE. Result is 0.
- RUN:
  - dsp_ce=1; in_ready=1.
  - Each handshake (in_valid & in_ready) increments sample_cnt.
  - Opmode pushed into the delay line each cycle:
    - FIRST on the first accepted pair
    - ACC on later accepted pairs
    - HOLD on bubble cycles (in_valid=0)
  - The handshake of pair number len goes DRAIN; in_ready drops the following cycle.
- DRAIN:
  - dsp_ce=1, in_ready=0; push HOLD into the delay line.
  - Stay OPM_DLY+P_LAT cycles, counted by an internal drain counter, then go DONE.
- DONE: done=1 for exactly one cycle; dsp_ce=0; then go IDLE. busy is deasserted in that IDLE cycle.
- start outside IDLE is ignored and not queued.
- Latency: done is asserted OPM_DLY+P_LAT+1 cycles after the last handshake.
- Bubbles do not stall the pipeline; HOLD keeps P stable while empty slots flow through.
- sample_cnt holds its final value until the next accepted start.
- len=2^CNT_W-1 must complete with no counter wrap; compare with equality on the captured len.

Optional Feature:
- Macro: DSP_MAC_SEQ_PERF_EN.
- When defined:
  - Adds output port bubble_cnt (CNT_W bits), which counts RUN cycles with in_valid=0.
  - It is cleared on start acceptance and on rst, and saturates at all-ones.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package dsp48_ctrl_pkg:
  - OPMODE constants FIRST/ACC/HOLD
  - state enum {IDLE, CLR, RUN, DRAIN, DONE}
- Sub-module dsp_opmode_dly:
  - OPM_DLY-deep, 8-bit shift register with ce and synchronous reset to HOLD.
  - OPM_DLY=0 is a pass-through.

Test Plan:
- len=4, in_valid held high → opmode sequence at the slice is 01,09,09,09, then HOLD. done fires 4 cycles after the 4th handshake with OPM_DLY=2 and P_LAT=1. P=sum of the 4 products.
- len=3 with in_valid pattern 1,0,0,1,0,1 → sample_cnt steps 1,1,1,2,2,3. HOLD appears in the bubble slots. P equals the 3-product sum.
- len=0 → dsp_rstp pulses for one cycle, done follows the next cycle, P=0.
- start asserted during RUN → ignored; sample_cnt and len are unchanged.
- rst asserted in the 2nd RUN cycle → next cycle all outputs are at reset values, no done pulse, and a fresh len=2 job completes correctly.
- With DSP_MAC_SEQ_PERF_EN defined, the pattern 1,0,1,0,0,1 for len=3 → bubble_cnt=3 at done.
